// File: rtl/pipe_control.sv
// Control unit for the 3-stage RV32I core (D decode, X execute, W writeback).
// Decodes the D instruction, carries the control bundle through X and W, and
// handles load-use / RAW stalls, redirect flushes, forwarding selects,
// illegal-opcode flagging and the cycle/instret counters.
module pipe_control #(
  parameter int FWD_EN      = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_WIDTH   = 32,
  parameter int CSR_EN      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst_d,
  input  logic                 inst_valid_d,
  input  logic                 br_eq_x,
  input  logic                 br_lt_x,
  output logic [2:0]           imm_sel_x,
  output logic [1:0]           a_sel_x,
  output logic [1:0]           b_sel_x,
  output logic [3:0]           alu_sel_x,
  output logic                 br_un_x,
  output logic                 mem_wen_x,
  output logic                 csr_sel_x,
  output logic                 csr_wen_x,
  output logic                 fwd_a_x,
  output logic                 fwd_b_x,
  output logic                 pc_sel,
  output logic                 stall_d,
  output logic                 reg_wen_w,
  output logic [1:0]           wb_sel_w,
  output logic [4:0]           rd_w,
  output logic                 illegal_x,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_S   = 3'd1;
  localparam logic [2:0] IMM_B   = 3'd2;
  localparam logic [2:0] IMM_U   = 3'd3;
  localparam logic [2:0] IMM_J   = 3'd4;
  localparam logic [2:0] IMM_CSR = 3'd5;

  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Control bundle held in X; an all-zero value is a bubble.
  typedef struct packed {
    logic       valid;
    logic [2:0] imm_sel;
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [3:0] alu_sel;
    logic       br_un;
    logic       mem_wen;
    logic       csr_sel;
    logic       csr_wen;
    logic       reg_wen;
    logic [1:0] wb_sel;
    logic       is_br;
    logic       is_jmp;
    logic [2:0] f3;
    logic [4:0] rs1;   // zero when the source is not used
    logic [4:0] rs2;
    logic [4:0] rd;    // zero when reg_wen is 0
  } ctl_t;

  ctl_t                 w_dec;
  logic                 w_legal;
  logic                 w_rs1_used;
  logic                 w_rs2_used;
  logic [6:0]           w_opcode;
  logic [2:0]           w_f3;
  logic                 w_d_live;
  logic                 w_lu_hit;
  logic                 w_raw_hit;
  logic                 w_hazard;
  logic                 w_kill_d;
  logic                 w_stall;
  logic                 w_take;
  logic                 w_taken;
  logic                 w_pc_sel;
  logic [5:0]           w_unused_bits;

  ctl_t                 r_x;
  logic                 r_illegal_x;
  logic                 r_kill;
  logic                 r_w_valid;
  logic                 r_w_wen;
  logic [1:0]           r_w_wb;
  logic [4:0]           r_w_rd;
  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_instret;

  assign w_opcode      = inst_d[6:0];
  assign w_f3          = inst_d[14:12];
  assign w_unused_bits = {inst_d[31], inst_d[29:25]};

  // Decode the D instruction into a control bundle.
  always_comb begin
    w_dec      = '0;
    w_legal    = 1'b1;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_dec.imm_sel = IMM_U;
        w_dec.b_sel   = B_IMM;
        w_dec.reg_wen = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.imm_sel = IMM_U;
        w_dec.a_sel   = A_PC;
        w_dec.b_sel   = B_IMM;
        w_dec.reg_wen = 1'b1;
      end
      OP_JAL: begin
        w_dec.imm_sel = IMM_J;
        w_dec.a_sel   = A_PC;
        w_dec.b_sel   = B_IMM;
        w_dec.wb_sel  = WB_PC4;
        w_dec.reg_wen = 1'b1;
        w_dec.is_jmp  = 1'b1;
      end
      OP_JALR: begin
        w_dec.imm_sel = IMM_I;
        w_dec.b_sel   = B_IMM;
        w_dec.wb_sel  = WB_PC4;
        w_dec.reg_wen = 1'b1;
        w_dec.is_jmp  = 1'b1;
        w_rs1_used    = 1'b1;
      end
      OP_BRANCH: begin
        w_dec.imm_sel = IMM_B;
        w_dec.a_sel   = A_PC;
        w_dec.b_sel   = B_IMM;
        w_dec.br_un   = w_f3[1];
        w_dec.is_br   = 1'b1;
        w_dec.f3      = w_f3;
        w_rs1_used    = 1'b1;
        w_rs2_used    = 1'b1;
      end
      OP_LOAD: begin
        w_dec.imm_sel = IMM_I;
        w_dec.b_sel   = B_IMM;
        w_dec.wb_sel  = WB_MEM;
        w_dec.reg_wen = 1'b1;
        w_rs1_used    = 1'b1;
      end
      OP_STORE: begin
        w_dec.imm_sel = IMM_S;
        w_dec.b_sel   = B_IMM;
        w_dec.mem_wen = 1'b1;
        w_rs1_used    = 1'b1;
        w_rs2_used    = 1'b1;
      end
      OP_IMM: begin
        w_dec.imm_sel = IMM_I;
        w_dec.b_sel   = B_IMM;
        w_dec.alu_sel = {(w_f3 == 3'b101) & inst_d[30], w_f3};
        w_dec.reg_wen = 1'b1;
        w_rs1_used    = 1'b1;
      end
      OP_REG: begin
        w_dec.alu_sel = {inst_d[30], w_f3};
        w_dec.reg_wen = 1'b1;
        w_rs1_used    = 1'b1;
        w_rs2_used    = 1'b1;
      end
      OP_FENCE: begin
        // Legal no-op in this core.
      end
      OP_SYSTEM: begin
        if (CSR_EN != 0) begin
          if (w_f3 != 3'b000) begin
            w_dec.imm_sel = IMM_CSR;
            w_dec.csr_sel = w_f3[2];
            w_dec.csr_wen = 1'b1;
            w_dec.reg_wen = 1'b1;
            w_rs1_used    = ~w_f3[2];
          end
        end else begin
          w_legal = 1'b0;
        end
      end
      default: w_legal = 1'b0;
    endcase
    w_dec.valid   = w_legal;
    w_dec.reg_wen = w_dec.reg_wen & (inst_d[11:7] != 5'd0);
    w_dec.rd      = w_dec.reg_wen ? inst_d[11:7] : 5'd0;
    w_dec.rs1     = w_rs1_used ? inst_d[19:15] : 5'd0;
    w_dec.rs2     = w_rs2_used ? inst_d[24:20] : 5'd0;
  end

  // Redirect decision for the instruction in X.
  always_comb begin
    w_taken = 1'b0;
    case (r_x.f3)
      3'b000:         w_taken = br_eq_x;
      3'b001:         w_taken = ~br_eq_x;
      3'b100, 3'b110: w_taken = br_lt_x;
      3'b101, 3'b111: w_taken = ~br_lt_x;
      default:        w_taken = 1'b0;
    endcase
    w_pc_sel = r_x.valid & (r_x.is_jmp | (r_x.is_br & w_taken));
  end

  // Hazard detection; a flush overrides any stall on the wrong-path instruction.
  always_comb begin
    w_d_live  = inst_valid_d & w_legal;
    w_lu_hit  = r_x.valid & r_x.reg_wen & (r_x.wb_sel == WB_MEM) &
                ((w_dec.rs1 == r_x.rd) | (w_dec.rs2 == r_x.rd));
    w_raw_hit = (r_x.valid & r_x.reg_wen &
                 ((w_dec.rs1 == r_x.rd) | (w_dec.rs2 == r_x.rd))) |
                (r_w_wen &
                 ((w_dec.rs1 == r_w_rd) | (w_dec.rs2 == r_w_rd)));
    w_hazard  = (FWD_EN != 0) ? w_lu_hit : w_raw_hit;
    w_kill_d  = w_pc_sel | r_kill;
    w_stall   = w_d_live & w_hazard & ~w_kill_d;
    w_take    = w_d_live & ~w_kill_d & ~w_stall;
  end

  // D->X and X->W pipeline registers plus the extra kill slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_illegal_x <= 1'b0;
      r_kill      <= 1'b0;
      r_w_valid   <= 1'b0;
      r_w_wen     <= 1'b0;
      r_w_wb      <= 2'd0;
      r_w_rd      <= 5'd0;
    end else begin
      r_x         <= w_take ? w_dec : '0;
      r_illegal_x <= inst_valid_d & ~w_legal & ~w_kill_d;
      r_kill      <= (FLUSH_SLOTS > 1) && w_pc_sel;
      r_w_valid   <= r_x.valid;
      r_w_wen     <= r_x.reg_wen;
      r_w_wb      <= r_x.wb_sel;
      r_w_rd      <= r_x.rd;
    end
  end

  // Free-running cycle counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle   <= r_cycle + CNT_WIDTH'(1);
      r_instret <= r_instret + CNT_WIDTH'(r_w_valid);
    end
  end

  assign imm_sel_x   = r_x.imm_sel;
  assign a_sel_x     = r_x.a_sel;
  assign b_sel_x     = r_x.b_sel;
  assign alu_sel_x   = r_x.alu_sel;
  assign br_un_x     = r_x.br_un;
  assign mem_wen_x   = r_x.mem_wen;
  assign csr_sel_x   = r_x.csr_sel;
  assign csr_wen_x   = r_x.csr_wen;
  assign fwd_a_x     = (FWD_EN != 0) && r_x.valid && r_w_wen &&
                       (r_w_rd == r_x.rs1) && (r_x.rs1 != 5'd0);
  assign fwd_b_x     = (FWD_EN != 0) && r_x.valid && r_w_wen &&
                       (r_w_rd == r_x.rs2) && (r_x.rs2 != 5'd0);
  assign pc_sel      = w_pc_sel;
  assign stall_d     = w_stall;
  assign reg_wen_w   = r_w_wen;
  assign wb_sel_w    = r_w_wb;
  assign rd_w        = r_w_rd;
  assign illegal_x   = r_illegal_x;
  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;

endmodule
